tensor_loader: RTL and testbench
================================

# tensor_loader

Sequencing reader that fetches one 3x3 tensor, nine consecutive signed 16-bit words, from data memory starting at a base address. It packs the words into a 144-bit tensor word for the A/B tensor registers feeding the MXU. It is the read-side counterpart of the tensor-result store path, which walks a 0..8 element counter, writes one element per cycle to `base + counter` and raises `tensor_op_done` at count 9. It uses the same element ordering and addressing, so a tensor stored at address X and then loaded from X reproduces the original 144-bit value.

## Interface
Parameters:
- `ELEM_W`, 16: element width in bits.
- `ADDR_W`, 9: data-memory address width.
- `N_ELEM`, 9: elements per tensor. Fixed at 9 when `TENSOR_LOADER_TRANSPOSE_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a load; sampled only when not busy.
- `base_addr`  in  ADDR_W  tensor base address; latched when `start` is accepted.
- `mem_rd_en`  out  1  data-memory read strobe.
- `mem_addr`  out  ADDR_W  data-memory read address.
- `mem_rd_data`  in  ELEM_W  read data; valid exactly one cycle after the cycle its address was driven.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  one-cycle pulse: `tensor_out` has just been updated.
- `tensor_out`  out  ELEM_W*N_ELEM  packed tensor. Element k is at `[ELEM_W*k+ELEM_W-1 : ELEM_W*k]`.

## Operation
- States:
  - IDLE: `start` accepted.
  - ISSUE: N_ELEM cycles, one read per cycle.
  - DRAIN: 1 cycle, captures the last word.
  - DONE: 1 cycle, `done`=1, `start` accepted.
- Transitions:
  - IDLE or DONE, `start`=1 → ISSUE; latch `base_addr`; issue index = 0.
  - IDLE or DONE, `start`=0 → IDLE.
  - ISSUE with issue index = N_ELEM-1 → DRAIN.
  - DRAIN → DONE.
- Reads in ISSUE:
  - `mem_rd_en`=1; `mem_addr` = (latched base + issue index) mod 2^ADDR_W.
  - The address wraps 511→0 silently; there is no error flag.
- Capture:
  - The word returned for index k is written into a shadow register at slot k during the cycle it is valid.
  - Captures occur in ISSUE cycles for indices 1..N_ELEM-1 and in DRAIN for the final index.
- Commit:
  - On entry to DONE, the shadow register is copied to `tensor_out` in a single update. It is never partially updated.
  - `tensor_out` then holds until the next completed load.
- `start` while busy (ISSUE/DRAIN) is ignored and not queued. `base_addr` changes after acceptance have no effect.
- `start` in the DONE cycle begins a new load immediately; `done` still pulses for the finished load.
- Reset values (asynchronous, any state):
  - state = IDLE; `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `tensor_out`=0, shadow=0.
  - A load interrupted by reset produces no `done` and does not alter `tensor_out` beyond its reset value.
- Elements are passed through bit-exact; no sign or width conversion.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high at the rising edge.
- Cycles 1..9: ISSUE, with `mem_addr` = base+0 .. base+8 and `busy`=1.
- Data for base+k arrives in cycle k+2.
- Cycle 10: DRAIN, `busy`=1, `mem_rd_en`=0.
- Cycle 11: DONE, `done`=1, `busy`=0, new `tensor_out` visible.
- Latency from `start` to `done` is 11 cycles.
- Back-to-back throughput is one tensor per 11 cycles when `start` is held high.
- All outputs are registered. There is no combinational path from `start`, `base_addr` or `mem_rd_data` to any output.

## Configuration
- `TENSOR_LOADER_TRANSPOSE_EN` defined:
  - The word read from base+k, with k = 3r+c, is stored at element slot 3c+r. This delivers the transpose of the row-major tensor in memory, for loading B operands column-major.
  - Slots 0, 4 and 8 are unaffected.
- Not defined: the word from base+k is stored at slot k (identity).
- Addresses, timing and handshake are identical in both builds.

## Test plan
- Basic load, identity build:
  - Stimulus: memory[10+k] = k+1; `start` with `base_addr`=10.
  - Required response: `mem_addr` 10..18 in cycles 1..9; `done` in cycle 11 only; `tensor_out` element k = k+1, i.e. 144'h0009_0008_…_0001.
- Wrap-around:
  - Stimulus: `base_addr`=508, memory[508..511] = 16'hA000..16'hA003, memory[0..4] = 16'hB000..16'hB004.
  - Required response: `mem_addr` sequence 508,509,510,511,0,1,2,3,4; elements 0..8 = A000..A003, B000..B004.
- Busy and back-to-back:
  - Stimulus: pulse `start` with base 0 in cycle 0 and base 100 in cycle 5; then hold `start`=1 with base 50 through cycle 11.
  - Required response: the cycle-5 request is ignored; the first `done` is in cycle 11 with base-0 data; a second load from 50 issues its first read in cycle 12, with `done` in cycle 22.
- Reset mid-load:
  - Stimulus: after a completed load from base 10, start a load from base 20 and drop `reset` in cycle 6.
  - Required response: immediately `mem_rd_en`=0, `busy`=0, `tensor_out`=0; no `done` is issued.
  - After release, a fresh load from base 10 completes in 11 cycles with correct data.
- Transpose build:
  - Stimulus: memory[k] = k, `start` with base 0.
  - Required response: `tensor_out` slots 0..8 = 0,3,6,1,4,7,2,5,8.
- Store/load round trip:
  - Stimulus: the tensor store path writes a known 144-bit MXU result at base 200; `tensor_loader` then loads from 200.
  - Required response: `tensor_out` equals the stored result bit-exact (identity build).

Source files
------------

// File: rtl/tensor_loader_if.sv
// Host and data-memory signals of the tensor loader, bundled as one interface.
// slave = loader side, master = host / memory side.
interface tensor_loader_if #(
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 9,
    parameter int N_ELEM = 9
);
    logic                       start;
    logic [ADDR_W-1:0]          base_addr;
    logic                       mem_rd_en;
    logic [ADDR_W-1:0]          mem_addr;
    logic [ELEM_W-1:0]          mem_rd_data;
    logic                       busy;
    logic                       done;
    logic [ELEM_W*N_ELEM-1:0]   tensor_out;

    modport master (
        output start, base_addr, mem_rd_data,
        input  mem_rd_en, mem_addr, busy, done, tensor_out
    );

    modport slave (
        input  start, base_addr, mem_rd_data,
        output mem_rd_en, mem_addr, busy, done, tensor_out
    );
endinterface

// File: rtl/tensor_loader.sv
// Fetches nine consecutive words from data memory and commits them as one packed tensor.
// Optional macro TENSOR_LOADER_TRANSPOSE_EN stores word 3r+c into slot 3c+r (column-major B operand).
module tensor_loader #(
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 9,
    parameter int N_ELEM = 9
) (
    input  logic            clk,
    input  logic            reset,
    tensor_loader_if.slave  bus
);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int TEN_W = ELEM_W * N_ELEM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_rd_en_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [TEN_W-1:0]  shadow_reg;
    logic [TEN_W-1:0]  shadow_next;
    logic [TEN_W-1:0]  tensor_out_reg;

    logic              cap_en;
    logic [IDX_W-1:0]  cap_idx;

    assign bus.mem_rd_en  = mem_rd_en_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.tensor_out = tensor_out_reg;

    // Read data lags its address by one cycle, so the word landing now belongs to idx-1,
    // and the last word lands while draining.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = LAST_IDX;
        if (state_reg == S_ISSUE && idx_reg != '0) begin
            cap_en  = 1'b1;
            cap_idx = idx_reg - IDX_W'(1);
        end else if (state_reg == S_DRAIN) begin
            cap_en  = 1'b1;
            cap_idx = LAST_IDX;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_slot
`ifdef TENSOR_LOADER_TRANSPOSE_EN
            // The 3x3 transpose is its own inverse, so slot gi is fed by read index 3c+r.
            localparam int SRC = (gi < 9) ? ((gi % 3) * 3 + gi / 3) : gi;
`else
            localparam int SRC = gi;
`endif
            localparam logic [IDX_W-1:0] SRC_IDX = IDX_W'(SRC);

            assign shadow_next[ELEM_W*gi +: ELEM_W] =
                (cap_en && cap_idx == SRC_IDX) ? bus.mem_rd_data
                                               : shadow_reg[ELEM_W*gi +: ELEM_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= shadow_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_rd_en_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            tensor_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_reg     <= S_ISSUE;
                        idx_reg       <= '0;
                        mem_addr_reg  <= bus.base_addr;
                        mem_rd_en_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= S_DRAIN;
                        mem_rd_en_reg <= 1'b0;
                    end else begin
                        idx_reg      <= idx_reg + IDX_W'(1);
                        mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Commit includes the word captured this very cycle.
                    state_reg      <= S_DONE;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b1;
                    tensor_out_reg <= shadow_next;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    mem_rd_en_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tensor_loader.sv
// Directed bench for tensor_loader: basic, wrap, back-to-back, reset mid-load, transpose, round trip.
module tb_tensor_loader;
    localparam int ELEM_W = 16;
    localparam int ADDR_W = 9;
    localparam int N_ELEM = 9;

`ifdef TENSOR_LOADER_TRANSPOSE_EN
    localparam logic [143:0] EXP_A    = 144'h0009_0006_0003_0008_0005_0002_0007_0004_0001;
    localparam logic [143:0] EXP_WRAP = 144'hB004_B001_A002_B003_B000_A001_B002_A003_A000;
    localparam logic [143:0] EXP_ZERO = 144'h0008_0005_0002_0007_0004_0001_0006_0003_0000;
    localparam logic [143:0] EXP_50   = 144'h5008_5005_5002_5007_5004_5001_5006_5003_5000;
    localparam logic [143:0] EXP_RT   = 144'h7FFF_FEDC_ABCD_8000_0001_5A5A_1234_FFFF_C3C3;
`else
    localparam logic [143:0] EXP_A    = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [143:0] EXP_WRAP = 144'hB004_B003_B002_B001_B000_A003_A002_A001_A000;
    localparam logic [143:0] EXP_ZERO = 144'h0008_0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [143:0] EXP_50   = 144'h5008_5007_5006_5005_5004_5003_5002_5001_5000;
    localparam logic [143:0] EXP_RT   = 144'h7FFF_8000_1234_FEDC_0001_FFFF_ABCD_5A5A_C3C3;
`endif
    localparam logic [143:0] MXU_RESULT = 144'h7FFF_8000_1234_FEDC_0001_FFFF_ABCD_5A5A_C3C3;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [143:0] prev_tensor;
    logic [15:0]  mem [0:511];

    always #5 clk = ~clk;

    tensor_loader_if #(.ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .N_ELEM(N_ELEM)) bus ();

    tensor_loader #(.ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .N_ELEM(N_ELEM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read memory: data for an address appears the cycle after it is driven.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        else               bus.mem_rd_data <= 16'hDEAD;
    end

    task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic store_tensor(input int base, input logic [143:0] value);
        for (int k = 0; k < 9; k++) mem[(base + k) % 512] = value[16*k +: 16];
    endtask

    // Full 11-cycle load with per-cycle checks on address, strobes and tensor hold.
    task automatic run_load(input string tag, input logic [8:0] base, input logic [143:0] exp);
        logic [8:0] exp_addr;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.base_addr = 9'h1FF;
            exp_addr = base + 9'(c - 1);
            if (c <= 9) check_val({tag, "_addr"}, bus.mem_addr, exp_addr);
            check_val({tag, "_rden"}, bus.mem_rd_en, c <= 9);
            check_val({tag, "_busy"}, bus.busy, c <= 10);
            check_val({tag, "_done"}, bus.done, c == 11);
            check_val({tag, "_tensor"}, bus.tensor_out, (c == 11) ? exp : prev_tensor);
        end
        $display("load %s base=%0d tensor=%h", tag, base, bus.tensor_out);
        prev_tensor = exp;
    endtask

    initial begin
        logic [8:0] exp_addr;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        prev_tensor   = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        for (int k = 0; k < 9; k++) mem[10 + k] = 16'(k + 1);
        repeat (3) @(negedge clk);
        check_val("rst_rden", bus.mem_rd_en, 1'b0);
        check_val("rst_addr", bus.mem_addr, 9'd0);
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_tensor", bus.tensor_out, 144'd0);
        $display("reset state checked");
        reset = 1'b1;

        run_load("basic", 9'd10, EXP_A);

        for (int k = 0; k < 4; k++) mem[508 + k] = 16'hA000 + 16'(k);
        for (int k = 0; k < 5; k++) mem[k] = 16'hB000 + 16'(k);
        run_load("wrap", 9'd508, EXP_WRAP);

        // Back-to-back: cycle-5 request ignored, start held through the DONE cycle.
        for (int k = 0; k < 9; k++) mem[k] = 16'(k);
        for (int k = 0; k < 9; k++) mem[50 + k] = 16'h5000 + 16'(k);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 9'd0;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c <= 9)                 exp_addr = 9'(c - 1);
            else if (c >= 12 && c <= 20) exp_addr = 9'(50 + c - 12);
            else                        exp_addr = bus.mem_addr;
            if (c <= 9 || (c >= 12 && c <= 20)) check_val("b2b_addr", bus.mem_addr, exp_addr);
            check_val("b2b_rden", bus.mem_rd_en, (c <= 9) || (c >= 12 && c <= 20));
            check_val("b2b_busy", bus.busy, (c <= 10) || (c >= 12 && c <= 21));
            check_val("b2b_done", bus.done, (c == 11) || (c == 22));
            if (c == 11) check_val("b2b_tensor0", bus.tensor_out, EXP_ZERO);
            if (c == 22) check_val("b2b_tensor50", bus.tensor_out, EXP_50);
            bus.start     = (c == 5) || (c >= 6 && c <= 11);
            bus.base_addr = (c == 5) ? 9'd100 : 9'd50;
        end
        bus.start = 1'b0;
        prev_tensor = EXP_50;
        $display("back-to-back sequence done tensor=%h", bus.tensor_out);

        // Reset in the middle of a load from base 20.
        run_load("pre_rst", 9'd10, EXP_A);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 9'd20;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_val("midload_busy", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        check_val("mrst_rden", bus.mem_rd_en, 1'b0);
        check_val("mrst_busy", bus.busy, 1'b0);
        check_val("mrst_tensor", bus.tensor_out, 144'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("mrst_done", bus.done, 1'b0);
        end
        reset = 1'b1;
        prev_tensor = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_val("post_rst_done", bus.done, 1'b0);
        end
        $display("reset mid-load checked");
        run_load("after_rst", 9'd10, EXP_A);

        run_load("transpose", 9'd0, EXP_ZERO);

        store_tensor(200, MXU_RESULT);
        run_load("roundtrip", 9'd200, EXP_RT);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
